// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, ALU-control codes, opcodes.
// Types and constants only; no timing or flow-control behaviour.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEM_ADR = 4'd2,
    MEM_RD  = 4'd3,
    MEM_WB  = 4'd4,
    MEM_WR  = 4'd5,
    R_EXE   = 4'd6,
    R_WB    = 4'd7,
    BRANCH  = 4'd8,
    I_EXE   = 4'd9,
    I_WB    = 4'd10,
    JUMP    = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_FUNCT = 3'b010,
    ALU_ADDI  = 3'b011,
    ALU_AND   = 3'b100,
    ALU_OR    = 3'b101,
    ALU_SLT   = 3'b110
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

endpackage

// File: rtl/mc_decode.sv
// Opcode decode: DECODE-state dispatch from the live opcode, execute-phase selects from the latched one.
// Purely combinational, zero latency; no handshake.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] dec_op,
  input  logic [5:0] exe_op,
  output state_t     dispatch,
  output logic       legal,
  output state_t     mem_next,
  output alu_op_t    imm_alu_op,
  output logic       br_on_ne
);

  always_comb begin
    dispatch = FETCH;
    legal    = 1'b1;
    case (dec_op)
      OP_RTYPE:                          dispatch = R_EXE;
      OP_LW, OP_SW:                      dispatch = MEM_ADR;
      OP_BEQ, OP_BNE:                    dispatch = BRANCH;
      OP_J:                              dispatch = JUMP;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: dispatch = I_EXE;
      default:                           legal    = 1'b0;
    endcase
  end

  always_comb begin
    imm_alu_op = ALU_ADDI;
    case (exe_op)
      OP_ANDI: imm_alu_op = ALU_AND;
      OP_ORI:  imm_alu_op = ALU_OR;
      OP_SLTI: imm_alu_op = ALU_SLT;
      default: imm_alu_op = ALU_ADDI;
    endcase
  end

  assign mem_next = (exe_op == OP_SW) ? MEM_WR : MEM_RD;
  assign br_on_ne = (exe_op == OP_BNE);

endmodule

// File: rtl/mc_ctrl.sv
// Moore multi-cycle datapath controller with retired-instruction counter (lw 5, sw/R/I 4, branch/jump 3 cycles).
// FETCH, MEM_RD and MEM_WR hold until mem_ready (ignored when MEM_WAIT=0).
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int MEM_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_src,
  output logic [2:0]  alu_op,
  output logic        illegal,
  output logic [31:0] retired,
  output logic [3:0]  state
);

  state_t     state_q, state_d;
  state_t     dispatch, mem_next;
  alu_op_t    imm_alu_op;
  logic [5:0] op_q;
  logic       rdy, legal, br_on_ne, retire;

  assign rdy   = (MEM_WAIT == 0) ? 1'b1 : mem_ready;
  assign state = state_q;

  mc_decode u_decode (
    .dec_op     (opcode),
    .exe_op     (op_q),
    .dispatch   (dispatch),
    .legal      (legal),
    .mem_next   (mem_next),
    .imm_alu_op (imm_alu_op),
    .br_on_ne   (br_on_ne)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (rdy) state_d = DECODE;
      DECODE:  state_d = dispatch;
      MEM_ADR: state_d = mem_next;
      MEM_RD:  if (rdy) state_d = MEM_WB;
      MEM_WR:  if (rdy) state_d = FETCH;
      R_EXE:   state_d = R_WB;
      I_EXE:   state_d = I_WB;
      default: state_d = FETCH;
    endcase
  end

  // Outputs are held inactive while reset is asserted so nothing strobes memory.
  always_comb begin
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    alu_op     = ALU_ADD;
    if (rst_n) begin
      case (state_q)
        FETCH: begin
          mem_read  = 1'b1;
          ir_write  = rdy;
          pc_en     = rdy;
          alu_src_b = 2'b01;
        end
        DECODE:  alu_src_b = 2'b11;
        MEM_ADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        R_EXE: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_SUB;
          pc_src    = 2'b01;
          pc_en     = br_on_ne ? ~zero : zero;
        end
        I_EXE: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = imm_alu_op;
        end
        I_WB:    reg_write = 1'b1;
        JUMP: begin
          pc_src = 2'b10;
          pc_en  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    retire = 1'b0;
    case (state_q)
      MEM_WB, R_WB, I_WB, BRANCH, JUMP: retire = 1'b1;
      MEM_WR:                           retire = rdy;
      default:                          retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= 6'd0;
      illegal <= 1'b0;
      retired <= 32'd0;
    end else begin
      if (state_q == DECODE) op_q <= opcode;
      illegal <= (state_q == DECODE) && !legal;
      if (retire) retired <= retired + 32'd1;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: instruction table through a scoreboard queue plus
// hand-written stall, reset and counter-wrap sequences.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, zero, mem_ready;
  logic [5:0]  opcode;
  logic        pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, pc_src;
  logic [2:0]  alu_op;
  logic        illegal;
  logic [31:0] retired;
  logic [3:0]  state;

  mc_ctrl #(.MEM_WAIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_op(alu_op),
    .illegal(illegal), .retired(retired), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]      op;
    logic            z;
    int              n;
    logic [4:0][3:0] seq;
  } vec_t;

  typedef struct {
    logic [3:0]  st;
    logic [15:0] ctl;
    logic        ill;
    logic [31:0] ret;
  } exp_t;

  vec_t        vecs [15];
  exp_t        sbq [$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_ret = 32'd0;
  logic        pend_ill = 1'b0;
  logic [15:0] ctl_act;

  assign ctl_act = {pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
                    reg_write, alu_src_a, alu_src_b, pc_src, alu_op};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected control word per state, straight from the state table.
  function automatic logic [15:0] exp_for(input logic [3:0] st, input logic [5:0] op,
                                          input logic z, input logic rdy);
    logic pe, io, mr, mw, irw, m2r, rd, rw, sa;
    logic [1:0] sb, ps;
    logic [2:0] ao;
    {pe, io, mr, mw, irw, m2r, rd, rw, sa} = 9'd0;
    sb = 2'b00; ps = 2'b00; ao = 3'b000;
    case (st)
      4'd0:  begin mr = 1; irw = rdy; pe = rdy; sb = 2'b01; end
      4'd1:  sb = 2'b11;
      4'd2:  begin sa = 1; sb = 2'b10; end
      4'd3:  begin mr = 1; io = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mw = 1; io = 1; end
      4'd6:  begin sa = 1; ao = 3'b010; end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin sa = 1; ao = 3'b001; ps = 2'b01; pe = (op == 6'b000101) ? ~z : z; end
      4'd9:  begin
        sa = 1; sb = 2'b10;
        ao = (op == 6'b001100) ? 3'b100 : (op == 6'b001101) ? 3'b101 :
             (op == 6'b001010) ? 3'b110 : 3'b011;
      end
      4'd10: rw = 1;
      4'd11: begin ps = 2'b10; pe = 1; end
      default: ;
    endcase
    return {pe, io, mr, mw, irw, m2r, rd, rw, sa, sb, ps, ao};
  endfunction

  // Caller is positioned at a falling edge; returns at the falling edge after the last cycle.
  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    for (int i = 0; i < v.n; i++) begin
      e.st  = v.seq[i];
      e.ctl = exp_for(v.seq[i], v.op, v.z, 1'b1);
      e.ill = (i == 0) && pend_ill;
      e.ret = exp_ret;
      sbq.push_back(e);
    end
    pend_ill = (v.n == 2);
    if (v.n > 2) exp_ret = exp_ret + 32'd1;
    for (int i = 0; i < v.n; i++) begin
      opcode    = (i == 1) ? v.op : ~v.op;
      zero      = v.z;
      mem_ready = 1'b1;
      #1;
      e = sbq.pop_front();
      chk($sformatf("v%0d_c%0d_state", idx, i), {28'd0, state}, {28'd0, e.st});
      chk($sformatf("v%0d_c%0d_ctl", idx, i), {16'd0, ctl_act}, {16'd0, e.ctl});
      chk($sformatf("v%0d_c%0d_illegal", idx, i), {31'd0, illegal}, {31'd0, e.ill});
      chk($sformatf("v%0d_c%0d_retired", idx, i), retired, e.ret);
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{6'b100011, 1'b0, 5, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}};
    vecs[1]  = '{6'b101011, 1'b0, 4, {4'd0, 4'd5, 4'd2, 4'd1, 4'd0}};
    vecs[2]  = '{6'b000000, 1'b1, 4, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}};
    vecs[3]  = '{6'b001000, 1'b0, 4, {4'd0, 4'd10, 4'd9, 4'd1, 4'd0}};
    vecs[4]  = '{6'b001100, 1'b0, 4, {4'd0, 4'd10, 4'd9, 4'd1, 4'd0}};
    vecs[5]  = '{6'b001101, 1'b1, 4, {4'd0, 4'd10, 4'd9, 4'd1, 4'd0}};
    vecs[6]  = '{6'b001010, 1'b0, 4, {4'd0, 4'd10, 4'd9, 4'd1, 4'd0}};
    vecs[7]  = '{6'b000100, 1'b1, 3, {4'd0, 4'd0, 4'd8, 4'd1, 4'd0}};
    vecs[8]  = '{6'b000100, 1'b0, 3, {4'd0, 4'd0, 4'd8, 4'd1, 4'd0}};
    vecs[9]  = '{6'b111111, 1'b0, 2, {4'd0, 4'd0, 4'd0, 4'd1, 4'd0}};
    vecs[10] = '{6'b000101, 1'b1, 3, {4'd0, 4'd0, 4'd8, 4'd1, 4'd0}};
    vecs[11] = '{6'b000101, 1'b0, 3, {4'd0, 4'd0, 4'd8, 4'd1, 4'd0}};
    vecs[12] = '{6'b000010, 1'b0, 3, {4'd0, 4'd0, 4'd11, 4'd1, 4'd0}};
    vecs[13] = '{6'b000001, 1'b0, 2, {4'd0, 4'd0, 4'd0, 4'd1, 4'd0}};
    vecs[14] = '{6'b100011, 1'b1, 5, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}};

    rst_n = 1'b0; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    #12;
    chk("rst_state", {28'd0, state}, 32'd0);
    chk("rst_ctl", {16'd0, ctl_act}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 15; k++) run_vec(k, vecs[k]);
    chk("sb_empty", sbq.size(), 32'd0);
    chk("table_retired", retired, exp_ret);

    // Fetch stalled three cycles, then a jump to finish it.
    opcode = 6'b000010;
    for (int c = 0; c < 4; c++) begin
      mem_ready = (c == 3);
      #1;
      chk($sformatf("stall_c%0d_state", c), {28'd0, state}, 32'd0);
      chk($sformatf("stall_c%0d_ir_write", c), {31'd0, ir_write}, (c == 3) ? 32'd1 : 32'd0);
      chk($sformatf("stall_c%0d_pc_en", c), {31'd0, pc_en}, (c == 3) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1 chk("stall_decode", {28'd0, state}, 32'd1);
    @(negedge clk);
    #1 chk("stall_jump", {28'd0, state}, 32'd11);
    @(negedge clk);
    exp_ret = exp_ret + 32'd1;
    chk("stall_retired", retired, exp_ret);

    // sw held in MEM_WR: no retire until the memory accepts.
    opcode = 6'b101011;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("swstall_c%0d_state", c), {28'd0, state}, 32'd5);
      chk($sformatf("swstall_c%0d_retired", c), retired, exp_ret);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    exp_ret = exp_ret + 32'd1;
    chk("swstall_done_state", {28'd0, state}, 32'd0);
    chk("swstall_retired", retired, exp_ret);

    // lw interrupted by asynchronous reset while waiting in MEM_RD.
    opcode = 6'b100011;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("memrd_state", {28'd0, state}, 32'd3);
    chk("memrd_rd_iord", {30'd0, mem_read, iord}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", {28'd0, state}, 32'd0);
    chk("arst_ctl", {16'd0, ctl_act}, 32'd0);
    chk("arst_retired", retired, 32'd0);
    @(negedge clk);
    chk("arst_hold_state", {28'd0, state}, 32'd0);
    rst_n = 1'b1;
    exp_ret = 32'd0;
    pend_ill = 1'b0;
    run_vec(100, vecs[12]);
    chk("post_rst_retired", retired, exp_ret);

    // Counter wrap from all-ones on a jump.
    force dut.retired = 32'hFFFF_FFFF;
    #1 release dut.retired;
    #1 chk("pre_wrap_retired", retired, 32'hFFFF_FFFF);
    exp_ret = 32'hFFFF_FFFF;
    run_vec(101, vecs[12]);
    chk("wrap_retired", retired, exp_ret);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
